// File: rtl/mips_ctrl_defs_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM.
// Holds state codes, opcode/funct constants, ALUOp codes, mux-select encodings
// and the instruction-class type produced by ctrl_op_decode.
package mips_ctrl_defs;

    // FSM state encodings (values are visible on the debug state port)
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_REXEC  = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_IEXEC  = 4'd8;
    localparam logic [3:0] S_IWB    = 4'd9;
    localparam logic [3:0] S_BRANCH = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_JR     = 4'd12;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Funct codes that change control flow or ALU operand A
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_JALR = 6'b001001;

    // ALUOp: [3]=unsigned, [2:0]=operation
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_FUNCT = 4'b0010;
    localparam logic [3:0] ALU_AND   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_ADDU  = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1101;

    // Mux select encodings
    localparam logic [1:0] RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10;
    localparam logic [1:0] M2R_ALUOUT = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10;
    localparam logic [1:0] SA_PC = 2'b00, SA_RS = 2'b01, SA_SHAMT = 2'b10, SA_ZERO = 2'b11;
    localparam logic [1:0] SB_RT = 2'b00, SB_FOUR = 2'b01, SB_IMM = 2'b10, SB_IMM_SL2 = 2'b11;
    localparam logic [1:0] PCS_ALU = 2'b00, PCS_ALUOUT = 2'b01, PCS_JUMP = 2'b10, PCS_RS = 2'b11;

    // Instruction class used to pick the post-DECODE state
    typedef enum logic [2:0] {
        CLS_MEM,
        CLS_JR,
        CLS_R,
        CLS_I,
        CLS_BR,
        CLS_J,
        CLS_ILL
    } iclass_e;

endpackage

// File: rtl/ctrl_op_decode.sv
// Purpose : combinational OpCode/Funct decode into instruction class and IEXEC ALU controls.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; outputs follow the IR fields directly.
// Ports: OpCode/Funct in; iclass, shift_op (R-type uses shamt), link (jal/jalr),
//        iexec_aluop/iexec_extop/iexec_luiop out.
module ctrl_op_decode
    import mips_ctrl_defs::*;
(
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    output iclass_e    iclass,
    output logic       shift_op,
    output logic       link,
    output logic [3:0] iexec_aluop,
    output logic       iexec_extop,
    output logic       iexec_luiop
);

    always_comb begin
        iclass      = CLS_ILL;
        link        = 1'b0;
        iexec_aluop = ALU_ADD;
        iexec_extop = 1'b1;
        iexec_luiop = 1'b0;

        case (OpCode)
            OP_LW, OP_SW: iclass = CLS_MEM;
            OP_RTYPE: begin
                if (Funct == F_JR || Funct == F_JALR) begin
                    iclass = CLS_JR;
                    link   = (Funct == F_JALR);
                end else begin
                    iclass = CLS_R;
                end
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI, OP_SLTIU, OP_LUI: iclass = CLS_I;
            OP_BEQ: iclass = CLS_BR;
            OP_J:   iclass = CLS_J;
            OP_JAL: begin
                iclass = CLS_J;
                link   = 1'b1;
            end
            default: iclass = CLS_ILL;
        endcase

        // Constant shifts take operand A from the shamt field
        shift_op = (Funct == F_SLL) || (Funct == F_SRL) || (Funct == F_SRA);

        case (OpCode)
            OP_ADDIU: iexec_aluop = ALU_ADDU;
            OP_ANDI: begin
                iexec_aluop = ALU_AND;
                iexec_extop = 1'b0;   // logical immediates are zero-extended
            end
            OP_SLTI:  iexec_aluop = ALU_SLT;
            OP_SLTIU: iexec_aluop = ALU_SLTU;
            OP_LUI: begin
                iexec_luiop = 1'b1;
                iexec_extop = 1'b0;
            end
            default: iexec_aluop = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose : Moore main control FSM for the multi-cycle MIPS datapath (fetch..writeback).
// Latency : lw 5 cycles; R/I/sw 4; beq/j/jal/jr/jalr 3 (plus memory wait cycles).
// Backpressure: with MEM_WAIT_EN, FETCH/MEMRD/MEMWR hold until mem_ready=1; otherwise none.
// Optional feature macro: MEM_WAIT_EN (adds mem_ready input).
// Ports: clk, reset (sync, active-high), OpCode/Funct from IR; datapath controls out;
//        instr_done/illegal one-cycle pulses; state = current FSM state for debug.
module multicycle_ctrl
    import mips_ctrl_defs::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         OpCode,
    input  logic [5:0]         Funct,
`ifdef MEM_WAIT_EN
    input  logic               mem_ready,
`endif
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemtoReg,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [3:0]         ALUOp,
    output logic               ExtOp,
    output logic               LuiOp,
    output logic [1:0]         PCSource,
    output logic               instr_done,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    logic [STATE_W-1:0] state_q, state_d;
    iclass_e            iclass;
    logic               shift_op, link;
    logic [3:0]         iexec_aluop;
    logic               iexec_extop, iexec_luiop;
    logic               mem_ok;

`ifdef MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    ctrl_op_decode u_dec (
        .OpCode      (OpCode),
        .Funct       (Funct),
        .iclass      (iclass),
        .shift_op    (shift_op),
        .link        (link),
        .iexec_aluop (iexec_aluop),
        .iexec_extop (iexec_extop),
        .iexec_luiop (iexec_luiop)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (iclass)
                    CLS_MEM: state_d = S_MEMADR;
                    CLS_JR:  state_d = S_JR;
                    CLS_R:   state_d = S_REXEC;
                    CLS_I:   state_d = S_IEXEC;
                    CLS_BR:  state_d = S_BRANCH;
                    CLS_J:   state_d = S_JUMP;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (OpCode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ok ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ok ? S_FETCH : S_MEMWR;
            S_REXEC:  state_d = S_RWB;
            S_IEXEC:  state_d = S_IWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output logic; everything is forced low while reset is held so no
    // partial write escapes in the reset cycle.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = RD_RT;
        MemtoReg    = M2R_ALUOUT;
        ALUSrcA     = SA_PC;
        ALUSrcB     = SB_RT;
        ALUOp       = ALU_ADD;
        ExtOp       = 1'b0;
        LuiOp       = 1'b0;
        PCSource    = PCS_ALU;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = mem_ok;
                    PCWrite = mem_ok;
                    ALUSrcB = SB_FOUR;
                end
                S_DECODE: begin
                    ALUSrcB = SB_IMM_SL2;
                    ExtOp   = 1'b1;
                    if (iclass == CLS_ILL) begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                S_MEMADR: begin
                    ALUSrcA = SA_RS;
                    ALUSrcB = SB_IMM;
                    ExtOp   = 1'b1;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = M2R_MDR;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    instr_done = mem_ok;
                end
                S_REXEC: begin
                    ALUSrcA = shift_op ? SA_SHAMT : SA_RS;
                    ALUOp   = ALU_FUNCT;
                end
                S_RWB: begin
                    RegWrite   = 1'b1;
                    RegDst     = RD_RD;
                    instr_done = 1'b1;
                end
                S_IEXEC: begin
                    ALUSrcA = iexec_luiop ? SA_ZERO : SA_RS;
                    ALUSrcB = SB_IMM;
                    ALUOp   = iexec_aluop;
                    ExtOp   = iexec_extop;
                    LuiOp   = iexec_luiop;
                end
                S_IWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = SA_RS;
                    ALUOp       = ALU_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PCS_ALUOUT;
                    instr_done  = 1'b1;
                end
                S_JUMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = PCS_JUMP;
                    instr_done = 1'b1;
                    if (link) begin
                        RegWrite = 1'b1;
                        RegDst   = RD_RA;
                        MemtoReg = M2R_PC;
                    end
                end
                S_JR: begin
                    PCWrite    = 1'b1;
                    PCSource   = PCS_RS;
                    instr_done = 1'b1;
                    if (link) begin
                        RegWrite = 1'b1;
                        RegDst   = RD_RD;
                        MemtoReg = M2R_PC;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Purpose : self-checking bench for multicycle_ctrl using a per-cycle expectation queue.
// Latency : expectations are queued per cycle and compared at each falling edge.
// Backpressure: mem_ready exercised only when MEM_WAIT_EN is defined.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, rw;
        logic [1:0] rdst, m2r, srca, srcb;
        logic [3:0] aluop;
        logic       ext, lui;
        logic [1:0] pcsrc;
        logic       done, ill;
    } ctl_t;

    typedef struct packed {
        logic [3:0] st;
        ctl_t       c;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OpCode, Funct;
`ifdef MEM_WAIT_EN
    logic       mem_ready = 1'b1;
`endif
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
    logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
    logic [3:0] ALUOp, state;
    logic       ExtOp, LuiOp, instr_done, illegal;
    ctl_t       act;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct),
`ifdef MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .ExtOp(ExtOp), .LuiOp(LuiOp), .PCSource(PCSource), .instr_done(instr_done),
        .illegal(illegal), .state(state)
    );

    always_comb act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                       RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, ExtOp, LuiOp, PCSource,
                       instr_done, illegal};

    function automatic ctl_t c_fetch();
        ctl_t c = '0;
        c.pcw = 1'b1; c.mrd = 1'b1; c.irw = 1'b1; c.srcb = 2'b01;
        return c;
    endfunction

    function automatic ctl_t c_decode();
        ctl_t c = '0;
        c.srcb = 2'b11; c.ext = 1'b1;
        return c;
    endfunction

    task automatic push(input logic [3:0] st, input ctl_t c);
        exp_q.push_back({st, c});
    endtask

    task automatic push_fd();
        push(4'd0, c_fetch());
        push(4'd1, c_decode());
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            tests += 2;
            if (state !== 4'd0) begin fails++; $display("FAIL reset_state got %0d want 0", state); end
            if (act !== ctl_t'(0)) begin fails++; $display("FAIL reset_outputs got %h want 0", act); end
        end
        reset = 1'b0;
    endtask

    task automatic test_lw_sw();
        exp_t e;
        ctl_t c;
        OpCode = 6'b100011; Funct = 6'b101010;
        push_fd();
        c = '0; c.srca = 2'b01; c.srcb = 2'b10; c.ext = 1'b1; push(4'd2, c);
        c = '0; c.mrd = 1'b1; c.iord = 1'b1; push(4'd3, c);
        c = '0; c.rw = 1'b1; c.m2r = 2'b01; c.done = 1'b1; push(4'd4, c);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); #1; tests += 2;
            if (state !== e.st) begin fails++; $display("FAIL lw state got %0d want %0d", state, e.st); end
            if (act !== e.c) begin fails++; $display("FAIL lw ctl st%0d got %h want %h", e.st, act, e.c); end
            @(negedge clk);
        end
        OpCode = 6'b101011;
        push_fd();
        c = '0; c.srca = 2'b01; c.srcb = 2'b10; c.ext = 1'b1; push(4'd2, c);
        c = '0; c.mwr = 1'b1; c.iord = 1'b1; c.done = 1'b1; push(4'd5, c);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); #1; tests += 2;
            if (state !== e.st) begin fails++; $display("FAIL sw state got %0d want %0d", state, e.st); end
            if (act !== e.c) begin fails++; $display("FAIL sw ctl st%0d got %h want %h", e.st, act, e.c); end
            @(negedge clk);
        end
    endtask

    task automatic test_rtype();
        exp_t e;
        ctl_t c;
        logic [5:0] fn [4] = '{6'b100001, 6'b000000, 6'b000011, 6'b101010};
        logic [1:0] sa [4] = '{2'b01, 2'b10, 2'b10, 2'b01};
        for (int i = 0; i < 4; i++) begin
            OpCode = 6'b000000; Funct = fn[i];
            push_fd();
            c = '0; c.srca = sa[i]; c.aluop = 4'b0010; push(4'd6, c);
            c = '0; c.rw = 1'b1; c.rdst = 2'b01; c.done = 1'b1; push(4'd7, c);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); #1; tests += 2;
                if (state !== e.st) begin fails++; $display("FAIL rtype f%b state got %0d want %0d", fn[i], state, e.st); end
                if (act !== e.c) begin fails++; $display("FAIL rtype f%b ctl got %h want %h", fn[i], act, e.c); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_itype();
        exp_t e;
        ctl_t c;
        logic [5:0] op [6] = '{6'b001011, 6'b001100, 6'b001111, 6'b001000, 6'b001001, 6'b001010};
        logic [3:0] ao [6] = '{4'b1101, 4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b0101};
        logic       ex [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       lu [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            OpCode = op[i]; Funct = 6'b001000;
            push_fd();
            c = '0; c.srca = lu[i] ? 2'b11 : 2'b01; c.srcb = 2'b10;
            c.aluop = ao[i]; c.ext = ex[i]; c.lui = lu[i];
            push(4'd8, c);
            c = '0; c.rw = 1'b1; c.done = 1'b1; push(4'd9, c);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); #1; tests += 2;
                if (state !== e.st) begin fails++; $display("FAIL itype op%b state got %0d want %0d", op[i], state, e.st); end
                if (act !== e.c) begin fails++; $display("FAIL itype op%b ctl got %h want %h", op[i], act, e.c); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_branch_jump();
        exp_t e;
        ctl_t c;
        logic [5:0] op [5] = '{6'b000100, 6'b000010, 6'b000011, 6'b000000, 6'b000000};
        logic [5:0] fn [5] = '{6'b001001, 6'b001001, 6'b001000, 6'b001000, 6'b001001};
        for (int i = 0; i < 5; i++) begin
            OpCode = op[i]; Funct = fn[i];
            push_fd();
            c = '0; c.done = 1'b1;
            case (i)
                0: begin c.srca = 2'b01; c.aluop = 4'b0001; c.pcwc = 1'b1; c.pcsrc = 2'b01; push(4'd10, c); end
                1: begin c.pcw = 1'b1; c.pcsrc = 2'b10; push(4'd11, c); end
                2: begin c.pcw = 1'b1; c.pcsrc = 2'b10; c.rw = 1'b1; c.rdst = 2'b10; c.m2r = 2'b10; push(4'd11, c); end
                3: begin c.pcw = 1'b1; c.pcsrc = 2'b11; push(4'd12, c); end
                default: begin c.pcw = 1'b1; c.pcsrc = 2'b11; c.rw = 1'b1; c.rdst = 2'b01; c.m2r = 2'b10; push(4'd12, c); end
            endcase
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); #1; tests += 2;
                if (state !== e.st) begin fails++; $display("FAIL flow op%b state got %0d want %0d", op[i], state, e.st); end
                if (act !== e.c) begin fails++; $display("FAIL flow op%b ctl got %h want %h", op[i], act, e.c); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_illegal();
        exp_t e;
        ctl_t c;
        OpCode = 6'b111111; Funct = 6'b000000;
        push(4'd0, c_fetch());
        c = c_decode(); c.ill = 1'b1; c.done = 1'b1; push(4'd1, c);
        // The following FETCH proves the FSM returned straight from DECODE
        push(4'd0, c_fetch());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); #1; tests += 2;
            if (state !== e.st) begin fails++; $display("FAIL illegal state got %0d want %0d", state, e.st); end
            if (act !== e.c) begin fails++; $display("FAIL illegal ctl got %h want %h", act, e.c); end
            if (e.st == 4'd0 && exp_q.size() == 0) OpCode = 6'b000010;
            @(negedge clk);
        end
        // finish the j that started in the trailing FETCH
        c = c_decode(); push(4'd1, c);
        c = '0; c.pcw = 1'b1; c.pcsrc = 2'b10; c.done = 1'b1; push(4'd11, c);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); #1; tests += 2;
            if (state !== e.st) begin fails++; $display("FAIL post_illegal state got %0d want %0d", state, e.st); end
            if (act !== e.c) begin fails++; $display("FAIL post_illegal ctl got %h want %h", act, e.c); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midflight();
        exp_t e;
        ctl_t c;
        OpCode = 6'b100011; Funct = 6'b000000;
        push_fd();
        c = '0; c.srca = 2'b01; c.srcb = 2'b10; c.ext = 1'b1; push(4'd2, c);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); #1; tests += 2;
            if (state !== e.st) begin fails++; $display("FAIL rst_mid state got %0d want %0d", state, e.st); end
            if (act !== e.c) begin fails++; $display("FAIL rst_mid ctl got %h want %h", act, e.c); end
            @(negedge clk);
        end
        reset = 1'b1; #1;
        tests += 2;
        if (state !== 4'd3) begin fails++; $display("FAIL rst_mid memrd_state got %0d want 3", state); end
        if (act !== ctl_t'(0)) begin fails++; $display("FAIL rst_mid memrd_outputs got %h want 0", act); end
        @(negedge clk); #1;
        tests++;
        if (state !== 4'd0) begin fails++; $display("FAIL rst_mid next_state got %0d want 0", state); end
        reset = 1'b0;
    endtask

`ifdef MEM_WAIT_EN
    task automatic test_mem_wait();
        exp_t e;
        ctl_t c;
        OpCode = 6'b000010; Funct = 6'b000000;
        mem_ready = 1'b0;
        c = c_fetch(); c.pcw = 1'b0; c.irw = 1'b0;
        repeat (3) push(4'd0, c);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); #1; tests += 2;
            if (state !== e.st) begin fails++; $display("FAIL fetch_wait state got %0d want %0d", state, e.st); end
            if (act !== e.c) begin fails++; $display("FAIL fetch_wait ctl got %h want %h", act, e.c); end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        push_fd();
        c = '0; c.pcw = 1'b1; c.pcsrc = 2'b10; c.done = 1'b1; push(4'd11, c);
        OpCode = 6'b000010;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); #1; tests += 2;
            if (state !== e.st) begin fails++; $display("FAIL fetch_go state got %0d want %0d", state, e.st); end
            if (act !== e.c) begin fails++; $display("FAIL fetch_go ctl got %h want %h", act, e.c); end
            @(negedge clk);
        end
        // sw held in MEMWR for two cycles
        OpCode = 6'b101011;
        push_fd();
        c = '0; c.srca = 2'b01; c.srcb = 2'b10; c.ext = 1'b1; push(4'd2, c);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); #1; tests += 2;
            if (state !== e.st) begin fails++; $display("FAIL sw_wait state got %0d want %0d", state, e.st); end
            if (act !== e.c) begin fails++; $display("FAIL sw_wait ctl got %h want %h", act, e.c); end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        c = '0; c.mwr = 1'b1; c.iord = 1'b1;
        repeat (2) push(4'd5, c);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); #1; tests += 2;
            if (state !== e.st) begin fails++; $display("FAIL memwr_wait state got %0d want %0d", state, e.st); end
            if (act !== e.c) begin fails++; $display("FAIL memwr_wait ctl got %h want %h", act, e.c); end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        c.done = 1'b1; push(4'd5, c);
        push(4'd0, c_fetch());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); #1; tests += 2;
            if (state !== e.st) begin fails++; $display("FAIL memwr_go state got %0d want %0d", state, e.st); end
            if (act !== e.c) begin fails++; $display("FAIL memwr_go ctl got %h want %h", act, e.c); end
            if (exp_q.size() == 1) OpCode = 6'b000010;
            @(negedge clk);
        end
        // complete the j begun in the trailing FETCH
        push(4'd1, c_decode());
        c = '0; c.pcw = 1'b1; c.pcsrc = 2'b10; c.done = 1'b1; push(4'd11, c);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); #1; tests += 2;
            if (state !== e.st) begin fails++; $display("FAIL memwr_tail state got %0d want %0d", state, e.st); end
            if (act !== e.c) begin fails++; $display("FAIL memwr_tail ctl got %h want %h", act, e.c); end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        reset  = 1'b1;
        OpCode = 6'b0;
        Funct  = 6'b0;
        test_reset();
        test_lw_sw();
        test_rtype();
        test_itype();
        test_branch_jump();
        test_illegal();
        test_reset_midflight();
`ifdef MEM_WAIT_EN
        test_mem_wait();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
